// File: rtl/msk_rcon_sched.sv
// Masked AES round-constant scheduler. It emits rcon values 01, 02, 04, ... as d-share
// words, one constant per ready handshake, and runs an IDLE/RUN/DONE control FSM.
module msk_rcon_sched #(
  parameter int d       = 2,
  parameter int NROUNDS = 10
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           start,
  input  logic           abort,
  input  logic           ready,
  output logic           out_valid,
  output logic [8*d-1:0] out,
  output logic [3:0]     round,
  output logic           last,
  output logic           busy,
  output logic           done
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam logic [3:0] LAST_ROUND = 4'(NROUNDS);

  state_t      state;
  state_t      state_next;
  logic [7:0]  rcon;

  function automatic logic [7:0] xtime(input logic [7:0] x);
    return {x[6:0], 1'b0} ^ (x[7] ? 8'h1B : 8'h00);
  endfunction

  // NOTE: every register here uses <= so that all flops update from the same
  // pre-edge values. Blocking assignments would create order-dependent simulation.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_next;
  end

  // NOTE: the first statement assigns state_next a default value. This stops any
  // path through the case from inferring a latch.
  always_comb begin
    state_next = state;
    unique case (state)
      IDLE: if (start && !abort) state_next = RUN;
      RUN: begin
        if (abort)                            state_next = IDLE;
        else if (ready && round == LAST_ROUND) state_next = DONE;
      end
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // The constant and round are cleared whenever the FSM is not heading into RUN.
  // Outside a run they therefore read as zero without further gating.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rcon  <= 8'h00;
      round <= 4'd0;
    end else if (state_next != RUN) begin
      rcon  <= 8'h00;
      round <= 4'd0;
    end else if (state == IDLE) begin
      rcon  <= 8'h01;
      round <= 4'd1;
    end else if (ready && round != LAST_ROUND) begin
      rcon  <= xtime(rcon);
      round <= round + 4'd1;
    end
  end

  // All outputs decode from registered state only. Each constant bit goes into the
  // top share of its group, and the remaining shares are zero.
  always_comb begin
    out_valid = (state == RUN);
    busy      = (state != IDLE);
    done      = (state == DONE);
    last      = (state == RUN) && (round == LAST_ROUND);
    out       = '0;
    if (state == RUN) begin
      for (int i = 0; i < 8; i++) out[i*d + d - 1] = rcon[i];
    end
  end

endmodule
